// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares one synchronous single-port RAM between
// the CPU data path (port 0) and the debug/program loader (port 1).
//
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   p0_* / p1_*           request side: req, we, addr, amp, wdata in;
//                         gnt (combinational), rvalid, rdata out
//   p1_lock               port 1 asks to keep the RAM for a burst
//   ram_*                 RAM side: addr/we/amp/data_in out, data_out in
//
// Round-robin, one access per cycle. Read data comes back one cycle
// after the grant and is steered to the port that owned that access.
// A port-1 lock is bounded by hold_cnt so the CPU always gets a slot
// after LOCK_MAX consecutive locked port-1 grants.
module dmem_arbiter #(
    parameter int AW       = 7,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [3:0]    p0_amp,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [3:0]    p1_amp,
    input  logic [DW-1:0] p1_wdata,
    input  logic          p1_lock,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,

    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [3:0]    ram_amp,
    output logic [DW-1:0] ram_data_in,
    input  logic [DW-1:0] ram_data_out
);

    localparam logic [7:0] HOLD_LIM = 8'(LOCK_MAX);

    logic       last_grant;
    logic [7:0] hold_cnt;
    logic       rd_pending;
    logic       rd_owner;

    logic both_req;
    logic hold_full;
    logic gnt0;
    logic gnt1;
    logic grant_any;
    logic grant_we;

    assign both_req  = p0_req & p1_req;
    assign hold_full = (hold_cnt >= HOLD_LIM);

    // Grant decision. Reset forces no grant so the RAM bus stays quiet
    // while rst is asserted, even if requesters keep req high.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (p0_req && !p1_req) begin
                gnt0 = 1'b1;
            end else if (p1_req && !p0_req) begin
                gnt1 = 1'b1;
            end else if (both_req) begin
                if (p1_lock && hold_full) begin
                    // Lock budget spent: CPU gets one slot.
                    gnt0 = 1'b1;
                end else if (p1_lock && last_grant) begin
                    gnt1 = 1'b1;
                end else if (last_grant) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign grant_any = gnt0 | gnt1;
    assign grant_we  = gnt1 ? p1_we : (gnt0 ? p0_we : 1'b0);

    // RAM drive from the granted port; all zero when idle.
    always_comb begin
        ram_addr    = '0;
        ram_we      = 1'b0;
        ram_amp     = '0;
        ram_data_in = '0;
        if (gnt1) begin
            ram_addr    = p1_addr;
            ram_we      = p1_we;
            ram_amp     = p1_amp;
            ram_data_in = p1_wdata;
        end else if (gnt0) begin
            ram_addr    = p0_addr;
            ram_we      = p0_we;
            ram_amp     = p0_amp;
            ram_data_in = p0_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            hold_cnt   <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            if (grant_any) begin
                last_grant <= gnt1;
                rd_owner   <= gnt1;
            end
            rd_pending <= grant_any & ~grant_we;

            // Only locked port-1 grants that actually held off the CPU
            // count against the budget.
            if (gnt0 || !p1_lock) begin
                hold_cnt <= '0;
            end else if (gnt1 && p0_req) begin
                if (!hold_full) begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
            end
        end
    end

    assign p0_rvalid = rd_pending & ~rd_owner;
    assign p1_rvalid = rd_pending &  rd_owner;
    assign p0_rdata  = p0_rvalid ? ram_data_out : '0;
    assign p1_rdata  = p1_rvalid ? ram_data_out : '0;

endmodule
